// File: rtl/pwm_duty_ramp.sv
// Avalon-MM slave that ramps, or breathes, the 8-bit on-time word fed to a PWM generator.
// One LSB step per programmable tick period; ramp completion and each breathe cycle raise irq_pend.
module pwm_duty_ramp #(
    parameter int PRESCALE_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  avs_address,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    output logic [7:0]  pwm_ontime,
    output logic        ramp_busy,
    output logic        irq
);

    typedef enum logic [1:0] {IDLE, RAMP, BR_UP, BR_DOWN} state_t;

    state_t                state;
    logic [7:0]            target;
    logic [PRESCALE_W-1:0] step_period;
    logic [PRESCALE_W-1:0] cnt;
    logic                  enable;
    logic                  irq_en;
    logic                  mode;
    logic                  irq_pend;

    logic [PRESCALE_W-1:0] period_m1;
    logic                  tick;
    logic [7:0]            pwm_inc;
    logic [7:0]            pwm_dec;
    logic [7:0]            ramp_next;
    logic                  breathing;
    logic                  irq_set;
    logic                  irq_clr;
    logic [31:0]           read_mux;
    logic                  unused_wdata;

    // A step period of zero is treated as one cycle per step.
    assign period_m1 = (step_period == '0) ? '0 : step_period - 1'b1;
    assign tick      = (state != IDLE) && (cnt == period_m1);
    assign pwm_inc   = (pwm_ontime == 8'hff) ? pwm_ontime : pwm_ontime + 8'd1;
    assign pwm_dec   = (pwm_ontime == 8'h00) ? pwm_ontime : pwm_ontime - 8'd1;
    assign ramp_next = (pwm_ontime < target) ? pwm_inc :
                       (pwm_ontime > target) ? pwm_dec : pwm_ontime;
    assign breathing = (state == BR_UP) || (state == BR_DOWN);

    // Any bus write swallows a tick landing in the same cycle, so no set event can coincide with it.
    assign irq_set = !avs_write && tick &&
                     (((state == RAMP) && (ramp_next == target)) ||
                      ((state == BR_DOWN) && (pwm_dec == 8'h00)));
    assign irq_clr = avs_write && (avs_address == 2'd3) && avs_writedata[9];

    assign ramp_busy    = (state != IDLE);
    assign irq          = irq_pend & irq_en;
    assign unused_wdata = ^avs_writedata;

    always_comb begin
        read_mux = '0;
        case (avs_address)
            2'd0:    read_mux = {24'd0, target};
            2'd1:    read_mux = 32'(step_period);
            2'd2:    read_mux = {29'd0, mode, irq_en, enable};
            default: read_mux = {22'd0, irq_pend, ramp_busy, pwm_ontime};
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            target       <= '0;
            step_period  <= PRESCALE_W'(1);
            cnt          <= '0;
            enable       <= 1'b0;
            irq_en       <= 1'b0;
            mode         <= 1'b0;
            irq_pend     <= 1'b0;
            pwm_ontime   <= '0;
            avs_readdata <= '0;
        end else begin
            if (avs_read) begin
                avs_readdata <= read_mux;
            end

            if (avs_write) begin
                cnt <= '0;
                case (avs_address)
                    2'd0: begin
                        target <= avs_writedata[7:0];
                        if ((state == RAMP) && (avs_writedata[7:0] == pwm_ontime)) begin
                            state <= IDLE;
                        end else if (breathing && (avs_writedata[7:0] == 8'h00)) begin
                            state <= IDLE;
                        end else if ((state == BR_UP) && (pwm_ontime > avs_writedata[7:0])) begin
                            state <= BR_DOWN;
                        end
                    end
                    2'd1: step_period <= avs_writedata[PRESCALE_W-1:0];
                    2'd2: begin
                        enable <= avs_writedata[0];
                        irq_en <= avs_writedata[1];
                        mode   <= avs_writedata[2];
                        if (avs_writedata[3]) begin
                            pwm_ontime <= target;
                        end
                        // Switching mode while running restarts from IDLE in the new mode.
                        if (avs_writedata[3] || !avs_writedata[0] ||
                            ((state == RAMP) && avs_writedata[2]) ||
                            (breathing && !avs_writedata[2])) begin
                            state <= IDLE;
                        end
                    end
                    default: ;
                endcase
            end else begin
                case (state)
                    IDLE: begin
                        cnt <= '0;
                        if (enable && !mode && (pwm_ontime != target)) begin
                            state <= RAMP;
                        end else if (enable && mode && (target != 8'h00)) begin
                            state <= BR_UP;
                        end
                    end
                    RAMP: begin
                        cnt <= tick ? '0 : cnt + 1'b1;
                        if (tick) begin
                            pwm_ontime <= ramp_next;
                            if (ramp_next == target) begin
                                state <= IDLE;
                            end
                        end
                    end
                    BR_UP: begin
                        cnt <= tick ? '0 : cnt + 1'b1;
                        if (tick) begin
                            // Already at or above the peak: turn around without moving.
                            if (pwm_ontime < target) begin
                                pwm_ontime <= pwm_inc;
                                if (pwm_inc == target) begin
                                    state <= BR_DOWN;
                                end
                            end else begin
                                state <= BR_DOWN;
                            end
                        end
                    end
                    default: begin
                        cnt <= tick ? '0 : cnt + 1'b1;
                        if (tick) begin
                            pwm_ontime <= pwm_dec;
                            if (pwm_dec == 8'h00) begin
                                state <= BR_UP;
                            end
                        end
                    end
                endcase
            end

            if (irq_set) begin
                irq_pend <= 1'b1;
            end else if (irq_clr) begin
                irq_pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Bench for pwm_duty_ramp: directed scenarios plus random register traffic, every cycle
// compared against a step-by-step behavioural model of the duty ramp.
module tb_pwm_duty_ramp;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  avs_address = '0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic        avs_read = 1'b0;
    logic [31:0] avs_readdata;
    logic [7:0]  pwm_ontime;
    logic        ramp_busy;
    logic        irq;

    int n_assert = 0;
    int n_fail   = 0;

    pwm_duty_ramp #(.PRESCALE_W(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .avs_address  (avs_address),
        .avs_write    (avs_write),
        .avs_writedata(avs_writedata),
        .avs_read     (avs_read),
        .avs_readdata (avs_readdata),
        .pwm_ontime   (pwm_ontime),
        .ramp_busy    (ramp_busy),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    // Reference model: "running" flag, breathe direction, and a countdown of cycles to the next step.
    int        m_pwm, m_tgt, m_period, m_left;
    bit        m_en, m_irqen, m_mode, m_pend, m_run, m_rise;
    bit [31:0] m_rd;

    function automatic int eff_period();
        return (m_period == 0) ? 1 : m_period;
    endfunction

    function automatic bit [31:0] reg_view(input bit [1:0] a);
        case (a)
            2'd0:    return 32'(m_tgt);
            2'd1:    return 32'(m_period);
            2'd2:    return {29'd0, m_mode, m_irqen, m_en};
            default: return {22'd0, m_pend, m_run, 8'(m_pwm)};
        endcase
    endfunction

    task automatic model_clock(input bit rst, input bit w, input bit [1:0] a,
                               input bit [31:0] d, input bit r);
        bit set_ev;
        bit clr_ev;
        int nt;
        if (rst) begin
            m_pwm = 0; m_tgt = 0; m_period = 1; m_left = 1;
            m_en = 0; m_irqen = 0; m_mode = 0; m_pend = 0; m_run = 0; m_rise = 0;
            m_rd = 0;
            return;
        end
        if (r) m_rd = reg_view(a);
        set_ev = 0;
        clr_ev = w && (a == 2'd3) && d[9];
        if (w) begin
            case (a)
                2'd0: begin
                    nt = int'(d[7:0]);
                    if (m_run) begin
                        if (!m_mode) begin
                            if (nt == m_pwm) m_run = 0;
                        end else if (nt == 0) begin
                            m_run = 0;
                        end else if (m_rise && m_pwm > nt) begin
                            m_rise = 0;
                        end
                    end
                    m_tgt = nt;
                end
                2'd1: m_period = int'(d[15:0]);
                2'd2: begin
                    if (d[3]) m_pwm = m_tgt;
                    if (d[3] || !d[0] || (m_run && (m_mode != d[2]))) m_run = 0;
                    m_en = d[0]; m_irqen = d[1]; m_mode = d[2];
                end
                default: ;
            endcase
            m_left = eff_period();
        end else if (!m_run) begin
            if (m_en && ((!m_mode && m_pwm != m_tgt) || (m_mode && m_tgt > 0))) begin
                m_run  = 1;
                m_rise = 1;
                m_left = eff_period();
            end
        end else begin
            m_left--;
            if (m_left == 0) begin
                m_left = eff_period();
                if (!m_mode) begin
                    if (m_pwm < m_tgt) m_pwm++;
                    else if (m_pwm > m_tgt) m_pwm--;
                    if (m_pwm == m_tgt) begin m_run = 0; set_ev = 1; end
                end else if (m_rise) begin
                    if (m_pwm < m_tgt) m_pwm++;
                    if (m_pwm >= m_tgt) m_rise = 0;
                end else begin
                    if (m_pwm > 0) m_pwm--;
                    if (m_pwm == 0) begin m_rise = 1; set_ev = 1; end
                end
            end
        end
        if (set_ev) m_pend = 1;
        else if (clr_ev) m_pend = 0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input bit rst, input bit w, input bit [1:0] a,
                         input bit [31:0] d, input bit r);
        @(negedge clk);
        reset         = rst;
        avs_write     = w;
        avs_address   = a;
        avs_writedata = d;
        avs_read      = r;
        model_clock(rst, w, a, d, r);
        @(posedge clk);
        #1;
        check("pwm_ontime", 32'(pwm_ontime), 32'(m_pwm));
        check("ramp_busy", 32'(ramp_busy), 32'(m_run));
        check("irq", 32'(irq), 32'(m_pend & m_irqen));
        check("readdata", avs_readdata, m_rd);
    endtask

    task automatic wr(input bit [1:0] a, input bit [31:0] d);
        cycle(0, 1, a, d, 0);
    endtask

    task automatic rd(input bit [1:0] a);
        cycle(0, 0, a, 0, 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 2'd0, 0, 0);
    endtask

    task automatic do_reset();
        for (int i = 0; i < 3; i++) cycle(1, 0, 2'd0, 0, 0);
    endtask

    // Bounded wait for the output to reach a value; a timeout shows up as a failed check.
    task automatic wait_pwm(input int v, input int limit);
        for (int i = 0; i < limit && pwm_ontime != 8'(v); i++) idle(1);
        check("wait_pwm", 32'(pwm_ontime), 32'(v));
    endtask

    initial begin
        bit [1:0]  ra;
        bit [31:0] rdat;

        // Reset state and reads after reset.
        do_reset();
        check("reset_pwm", 32'(pwm_ontime), 32'd0);
        rd(2'd3);
        check("reset_status", avs_readdata, 32'h000);
        rd(2'd2);
        check("reset_control", avs_readdata, 32'h0);
        rd(2'd1);
        check("reset_step", avs_readdata, 32'h1);

        // Ramp up 0 -> 10 at 4 cycles per step with irq enabled.
        wr(2'd1, 32'd4);
        wr(2'd0, 32'd10);
        wr(2'd2, 32'h3);
        idle(45);
        check("ramp_up_end", 32'(pwm_ontime), 32'd10);
        check("ramp_up_irq", 32'(irq), 32'd1);
        rd(2'd3);
        check("ramp_up_status", avs_readdata, 32'h20A);
        wr(2'd3, 32'h200);
        check("w1c_irq", 32'(irq), 32'd0);

        // Ramp down 10 -> 7 with step period 0 (one step per cycle).
        wr(2'd1, 32'd0);
        wr(2'd0, 32'd7);
        idle(5);
        check("ramp_down_end", 32'(pwm_ontime), 32'd7);
        check("ramp_down_busy", 32'(ramp_busy), 32'd0);

        // Breathe 0..3 at 2 cycles per step.
        do_reset();
        wr(2'd1, 32'd2);
        wr(2'd0, 32'd3);
        wr(2'd2, 32'h5);
        idle(20);
        rd(2'd3);
        check("breathe_pend", 32'(avs_readdata[9]), 32'd1);
        idle(30);

        // Disable mid-ramp at 5, then load_now.
        do_reset();
        wr(2'd0, 32'd20);
        wr(2'd2, 32'h3);
        wait_pwm(5, 40);
        wr(2'd2, 32'h0);
        idle(3);
        check("hold_pwm", 32'(pwm_ontime), 32'd5);
        check("hold_busy", 32'(ramp_busy), 32'd0);
        wr(2'd0, 32'd30);
        wr(2'd2, 32'h8);
        check("load_now_pwm", 32'(pwm_ontime), 32'd30);
        rd(2'd2);
        check("load_now_reads0", avs_readdata, 32'h0);
        rd(2'd3);
        check("load_now_noirq", avs_readdata, 32'h01E);

        // Reset mid-ramp at 100.
        wr(2'd0, 32'd200);
        wr(2'd2, 32'h1);
        wait_pwm(100, 150);
        cycle(1, 0, 2'd0, 0, 0);
        check("reset_mid_pwm", 32'(pwm_ontime), 32'd0);
        rd(2'd1);
        check("reset_mid_step", avs_readdata, 32'h1);

        // Write landing on a tick: STATUS writes every few cycles during a slow ramp.
        wr(2'd1, 32'd3);
        wr(2'd0, 32'd50);
        wr(2'd2, 32'h3);
        for (int i = 0; i < 10; i++) begin
            idle(int'($urandom_range(1, 3)));
            wr(2'd3, 32'h0);
        end

        // Random register traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                ra = 2'($urandom_range(0, 3));
                case (ra)
                    2'd0:    rdat = $urandom_range(0, 24);
                    2'd1:    rdat = $urandom_range(0, 3);
                    2'd2:    rdat = {28'd0, ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0,
                                     3'($urandom_range(0, 7)) | (($urandom_range(0, 3) != 0) ? 3'b001 : 3'b000)};
                    default: rdat = $urandom() & 32'h0000_03ff;
                endcase
                wr(ra, rdat);
            end else begin
                cycle(0, 0, 2'($urandom_range(0, 3)), 0, $urandom_range(0, 2) == 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
